keypad_matrix_scanner: RTL
==========================

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of sense lines H.
REQ-002 SHALL have parameter COLS, default 4, number of drive lines V.
REQ-003 SHALL have parameter DWELL, default 4 (≥2), clock cycles each column is driven.
REQ-004 SHALL have parameter DEB, default 4 (≥1), consecutive agreeing frame samples needed to change a key state.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8 (power of two, ≥2), event queue depth.
REQ-006 Clock  input  1  sole clock, all state on rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 H  input  ROWS  row sense lines, externally pulled down, 1 = contact closed to driven column.
REQ-009 V  output  COLS  column drive lines, one-hot high during scan.
REQ-010 res  output  ROWS*COLS  debounced key map, bit c*ROWS+r = key at column c, row r.
REQ-011 evt_valid  output  1  event word available at queue head.
REQ-012 evt_ready  input  1  consumer accepts head event when high with evt_valid.
REQ-013 evt_col  output  clog2(COLS) (min 1)  column of head event.
REQ-014 evt_press / evt_rel  output  ROWS each  rows that became pressed / released.
REQ-015 evt_ovf  output  1  one-cycle pulse when an event is dropped.

Function
REQ-016 Scanner SHALL drive column c for DWELL cycles, c = 0..COLS-1 ascending, wrapping to 0; one frame = COLS*DWELL cycles.
REQ-017 H SHALL be sampled only on the last dwell cycle of each column (earlier cycles are settling time).
REQ-018 Per key, a DEB-frame counter SHALL count consecutive samples differing from res; any agreeing sample clears it; on reaching DEB, the res bit toggles and the counter clears.
REQ-019 res SHALL update on the clock edge following the qualifying sample; bounce shorter than DEB frames SHALL produce no res change.
REQ-020 If any key in a column changes at its sample, exactly one event {col, press mask, release mask} SHALL be pushed that same update edge; no change, no push.
REQ-021 Queue SHALL be FIFO; pop when evt_valid && evt_ready; head outputs stable while evt_valid && !evt_ready.
REQ-022 Push while full SHALL drop the new event, keep queue contents, pulse evt_ovf one cycle; res still updates.
REQ-023 Simultaneous push and pop while full SHALL succeed (no drop).
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH with a separate full/empty distinction (extra pointer bit or count).

Reset
REQ-025 While Reset low: V=0, res=0, all debounce counters 0, FIFO empty, evt_valid=0, evt_col/evt_press/evt_rel=0, evt_ovf=0.
REQ-026 First rising edge after Reset release SHALL drive column 0 for a full DWELL.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard all partial state; no event emitted for it.

Configuration
REQ-028 Macro KEYPAD_EVENT_FIFO_EN defined: event queue and REQ-020..024 present.
REQ-029 Macro undefined: no queue logic; evt_valid, evt_col, evt_press, evt_rel, evt_ovf tied 0; evt_ready ignored; res behaviour identical.

Structure
REQ-030 Shared package keypad_pkg SHALL hold the event record typedef (col, press, rel), default parameter constants and the key-index function c*ROWS+r.
REQ-031 Event queue SHALL be a sub-module keypad_evt_fifo (parametrised width and depth), instantiated only under KEYPAD_EVENT_FIFO_EN.

Verification (defaults, frame = 16 cycles)
REQ-032 Key 5 (col 1, row 1) closed cleanly -> res=16'h0020 within 5 frames (≤80 cycles), one event col=1 press=4'b0010 rel=0.
REQ-033 Key 9 toggled 8 times every 4 cycles then held closed -> res bit 9 rises exactly once, one press event, no release event.
REQ-034 Keys 0 and 3 closed together, then released -> one event col=0 press=4'b1001, later one event col=0 rel=4'b1001, res back to 0.
REQ-035 evt_ready=0, 9 distinct column changes -> 8 events queued unchanged, evt_ovf pulses once; evt_ready=1 drains 8 in push order.
REQ-036 Reset pulsed low mid-debounce of key 12 -> all outputs 0 immediately, no event, scan restarts at column 0.
REQ-037 Build without KEYPAD_EVENT_FIFO_EN, rerun REQ-032 -> identical res, evt_valid constantly 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, default parameters and key indexing for the keypad matrix scanner.
package keypad_pkg;

  localparam int unsigned DEF_ROWS       = 4;
  localparam int unsigned DEF_COLS       = 4;
  localparam int unsigned DEF_DWELL      = 4;
  localparam int unsigned DEF_DEB        = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Event record is sized for the largest supported matrix (16 rows, 32 columns);
  // smaller instances leave the upper bits at zero.
  localparam int unsigned MAX_ROWS  = 16;
  localparam int unsigned MAX_COL_W = 5;

  typedef struct packed {
    logic [MAX_COL_W-1:0] col;
    logic [MAX_ROWS-1:0]  press;
    logic [MAX_ROWS-1:0]  rel;
  } keypad_evt_t;

  function automatic int unsigned key_idx(input int unsigned col, input int unsigned row,
                                          input int unsigned rows);
    return col * rows + row;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Event queue for the keypad scanner: drops new entries when full (ovf pulse), push+pop when full succeeds.
module keypad_evt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= i_push && w_full && !w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_valid = !w_empty;
  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning keypad reader with per-key frame debounce; the event queue is built
// only when KEYPAD_EVENT_FIFO_EN is defined, otherwise all event outputs are tied to zero.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int unsigned ROWS       = DEF_ROWS,
  parameter  int unsigned COLS       = DEF_COLS,
  parameter  int unsigned DWELL      = DEF_DWELL,
  parameter  int unsigned DEB        = DEF_DEB,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [ROWS-1:0]      H,
  output logic [COLS-1:0]      V,
  output logic [ROWS*COLS-1:0] res,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [COL_W-1:0]     evt_col,
  output logic [ROWS-1:0]      evt_press,
  output logic [ROWS-1:0]      evt_rel,
  output logic                 evt_ovf
);

  localparam int unsigned KEYS  = ROWS * COLS;
  localparam int unsigned DW_W  = $clog2(DWELL);
  localparam int unsigned CNT_W = $clog2(DEB + 1);

  logic             r_run;
  logic [COL_W-1:0] r_col;
  logic [DW_W-1:0]  r_dwell;
  logic [KEYS-1:0]  r_res;
  logic [KEYS-1:0]  w_tog;
  logic             w_sample;

  // r_run stays low until the first edge after reset so column 0 gets a full dwell.
  assign w_sample = r_run && (r_dwell == DW_W'(DWELL - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_run   <= 1'b0;
      r_col   <= '0;
      r_dwell <= '0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_col   <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  always_comb begin
    V = '0;
    if (r_run) V[r_col] = 1'b1;
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      localparam int unsigned K = key_idx(gc, gr, ROWS);
      logic [CNT_W-1:0] r_cnt;
      logic             w_hit;
      logic             w_diff;
      logic             w_done;

      assign w_hit    = w_sample && (r_col == COL_W'(gc));
      assign w_diff   = H[gr] ^ r_res[K];
      assign w_done   = (r_cnt == CNT_W'(DEB - 1));
      assign w_tog[K] = w_hit && w_diff && w_done;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          r_cnt <= '0;
        end else if (w_hit) begin
          r_cnt <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_res <= '0;
    else        r_res <= r_res ^ w_tog;
  end

  assign res = r_res;

`ifdef KEYPAD_EVENT_FIFO_EN
  logic [ROWS-1:0] w_press;
  logic [ROWS-1:0] w_rel;
  keypad_evt_t     w_evt;
  keypad_evt_t     w_head;
  logic            w_push;
  logic            w_unused_head;

  // Toggles only occur in the column being sampled, so OR-ing across columns is safe.
  always_comb begin
    w_press = '0;
    w_rel   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (w_tog[key_idx(c, r, ROWS)]) begin
          if (H[r]) w_press[r] = 1'b1;
          else      w_rel[r]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_evt                  = '0;
    w_evt.col[COL_W-1:0]   = r_col;
    w_evt.press[ROWS-1:0]  = w_press;
    w_evt.rel[ROWS-1:0]    = w_rel;
  end

  assign w_push = |{w_press, w_rel};

  keypad_evt_fifo #(
    .WIDTH ($bits(keypad_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_push  (w_push),
    .i_wdata (w_evt),
    .i_ready (evt_ready),
    .o_valid (evt_valid),
    .o_rdata (w_head),
    .o_ovf   (evt_ovf)
  );

  assign w_unused_head = ^w_head;
  assign evt_col       = w_head.col[COL_W-1:0];
  assign evt_press     = w_head.press[ROWS-1:0];
  assign evt_rel       = w_head.rel[ROWS-1:0];
`else
  logic w_unused_ready;

  assign w_unused_ready = evt_ready;
  assign evt_valid      = 1'b0;
  assign evt_col        = '0;
  assign evt_press      = '0;
  assign evt_rel        = '0;
  assign evt_ovf        = 1'b0;
`endif

endmodule
